banda_ctrl: RTL and testbench

Pipeline controller and two-requester scheduler for the three-stage assembly line (bloc → registru chain). It arbitrates round-robin between two item sources, admits one item per cycle, and generates per-stage register load enables with bubble collapse and output backpressure. It also tracks per-stage valid/tag bits, occupancy and per-requester completions. It sits beside the datapath; the datapath registers load only when the matching `en` bit is high.

---
 rtl/banda_pkg.sv | 12 +
 rtl/banda_rr_arb.sv | 35 +++
 rtl/banda_ctrl.sv | 108 ++++++++++
 tb/tb_banda_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/banda_pkg.sv
// Shared constants and types for the banda assembly-line controller.
`timescale 1ns/1ps
package banda_pkg;

  localparam int unsigned BANDA_STAGES_DEFAULT = 3;

  typedef logic banda_tag_t;

  localparam banda_tag_t REQ0 = 1'b0;
  localparam banda_tag_t REQ1 = 1'b1;

endpackage

// File: rtl/banda_rr_arb.sv
// Two-way round-robin arbiter; the pointer favours the requester that lost last time.
`timescale 1ns/1ps
module banda_rr_arb
  import banda_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  banda_tag_t ptr;

  always_comb begin
    gnt = '0;
    if (enable && !reset) begin
      if (req == 2'b11) begin
        gnt = (ptr == REQ1) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Granting requester 0 hands priority to requester 1 and vice versa.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= REQ0;
    end else if (|gnt) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/banda_ctrl.sv
// Pipeline controller: admission arbiter, valid/tag shift chain with bubble collapse,
// occupancy tracking and per-requester completion counters.
`timescale 1ns/1ps
module banda_ctrl
  import banda_pkg::*;
#(
  parameter int unsigned STAGES = BANDA_STAGES_DEFAULT,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req,
  output logic [1:0]                 gnt,
  input  logic                       flush,
  output logic [STAGES-1:0]          en,
  output logic [STAGES-1:0]          stage_valid,
  output logic                       out_valid,
  output logic                       out_tag,
  input  logic                       out_ready,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           done0,
  output logic [CNT_W-1:0]           done1
);

  localparam int unsigned OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] tag;
  logic [STAGES-1:0] adv;
  logic              in_ready;
  logic              grant_any;
  logic              emit;
  logic [OCC_W-1:0]  occ_q;

  // A stage may load when it is empty or the stage downstream of it moves.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~v[STAGES-1] | out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      adv[STAGES-1-i] = ~v[STAGES-1-i] | adv[STAGES-i];
    end
  end

  assign en          = adv;
  assign in_ready    = adv[0] & ~flush;
  assign grant_any   = |gnt;
  assign emit        = v[STAGES-1] & out_ready;
  assign stage_valid = v;
  assign out_valid   = v[STAGES-1];
  assign out_tag     = tag[STAGES-1];
  assign occupancy   = occ_q;

  banda_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .enable (in_ready),
    .gnt    (gnt)
  );

  // Flush clears valids only; tags are left in place since nothing reads them unqualified.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v   <= '0;
      tag <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      if (adv[0]) begin
        v[0]   <= grant_any;
        tag[0] <= gnt[1];
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k]   <= v[k-1];
          tag[k] <= tag[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (grant_any && !emit) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (!grant_any && emit) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

  // The last-stage item still counts as emitted in a flush cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done0 <= '0;
      done1 <= '0;
    end else if (emit) begin
      if (tag[STAGES-1] == REQ1) begin
        if (done1 != '1) done1 <= done1 + CNT_W'(1);
      end else begin
        if (done0 != '1) done0 <= done0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_banda_ctrl.sv
// Directed scoreboard bench for banda_ctrl (STAGES=3, CNT_W=8).
`timescale 1ns/1ps
module tb_banda_ctrl;
  import banda_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       flush;
  logic [2:0] en;
  logic [2:0] stage_valid;
  logic       out_valid;
  logic       out_tag;
  logic       out_ready;
  logic [1:0] occupancy;
  logic [7:0] done0;
  logic [7:0] done1;

  int checks   = 0;
  int failures = 0;
  banda_tag_t exp_q[$];

  banda_ctrl #(.STAGES(3), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .gnt         (gnt),
    .flush       (flush),
    .en          (en),
    .stage_valid (stage_valid),
    .out_valid   (out_valid),
    .out_tag     (out_tag),
    .out_ready   (out_ready),
    .occupancy   (occupancy),
    .done0       (done0),
    .done1       (done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic ordy, input logic fl);
    req = r;
    out_ready = ordy;
    flush = fl;
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted output item must match the oldest expected tag.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_tag unexpected item actual=%0d required=none", out_tag);
      end else begin
        chk("out_tag", 32'(out_tag), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req = 2'b11; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_en", 32'(en), 32'h7);
    chk("rst_occ", 32'(occupancy), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle after reset
    drive(2'b00, 1'b0, 1'b0);
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_occ", 32'(occupancy), 0);
    chk("idle_en", 32'(en), 32'h7);
    next_cyc();

    // Continuous admission, both requesting
    for (int c = 0; c < 6; c++) begin
      drive(2'b11, 1'b1, 1'b0);
      chk("cont_gnt", 32'(gnt), (c % 2 == 0) ? 32'h1 : 32'h2);
      exp_q.push_back((c % 2 == 0) ? REQ0 : REQ1);
      chk("cont_out_valid", 32'(out_valid), (c >= 3) ? 1 : 0);
      chk("cont_occ", 32'(occupancy), (c < 3) ? 32'(c) : 3);
      chk("cont_en", 32'(en), 32'h7);
      next_cyc();
    end
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, 1'b1, 1'b0);
      chk("drain_out_valid", 32'(out_valid), 1);
      next_cyc();
    end
    drive(2'b00, 1'b1, 1'b0);
    chk("cont_empty", 32'(out_valid), 0);
    chk("cont_occ_end", 32'(occupancy), 0);
    chk("cont_done0", 32'(done0), 3);
    chk("cont_done1", 32'(done1), 3);
    next_cyc();

    // Backpressure
    for (int c = 0; c < 3; c++) begin
      drive(2'b01, 1'b0, 1'b0);
      chk("bp_fill_gnt", 32'(gnt), 32'h1);
      exp_q.push_back(REQ0);
      next_cyc();
    end
    drive(2'b01, 1'b0, 1'b0);
    chk("bp_full_occ", 32'(occupancy), 3);
    chk("bp_full_en", 32'(en), 0);
    chk("bp_full_gnt", 32'(gnt), 0);
    chk("bp_full_sv", 32'(stage_valid), 32'h7);
    next_cyc();
    drive(2'b01, 1'b1, 1'b0);
    chk("bp_release_gnt", 32'(gnt), 32'h1);
    chk("bp_release_en", 32'(en), 32'h7);
    exp_q.push_back(REQ0);
    next_cyc();
    drive(2'b00, 1'b0, 1'b0);
    chk("bp_after_occ", 32'(occupancy), 3);
    chk("bp_after_done0", 32'(done0), 4);
    chk("bp_after_en", 32'(en), 0);
    next_cyc();
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, 1'b1, 1'b0);
      next_cyc();
    end
    drive(2'b00, 1'b1, 1'b0);
    chk("bp_end_occ", 32'(occupancy), 0);
    chk("bp_end_done0", 32'(done0), 7);
    chk("bp_end_done1", 32'(done1), 3);
    next_cyc();

    // Bubble collapse under backpressure
    drive(2'b01, 1'b0, 1'b0);
    chk("bub_gnt_a", 32'(gnt), 32'h1);
    exp_q.push_back(REQ0);
    next_cyc();
    drive(2'b00, 1'b0, 1'b0);
    next_cyc();
    drive(2'b10, 1'b0, 1'b0);
    chk("bub_gnt_b", 32'(gnt), 32'h2);
    chk("bub_sv_a1", 32'(stage_valid), 32'h2);
    exp_q.push_back(REQ1);
    next_cyc();
    drive(2'b00, 1'b0, 1'b0);
    chk("bub_sv_101", 32'(stage_valid), 32'h5);
    next_cyc();
    drive(2'b00, 1'b0, 1'b0);
    chk("bub_sv_110", 32'(stage_valid), 32'h6);
    chk("bub_en", 32'(en), 32'h1);
    next_cyc();
    drive(2'b00, 1'b0, 1'b0);
    chk("bub_sv_hold", 32'(stage_valid), 32'h6);
    chk("bub_occ", 32'(occupancy), 2);
    next_cyc();

    // Flush with full pipe and out_ready high
    drive(2'b01, 1'b0, 1'b0);
    chk("fl_fill_gnt", 32'(gnt), 32'h1);
    exp_q.push_back(REQ0);
    next_cyc();
    drive(2'b11, 1'b1, 1'b1);
    chk("fl_gnt", 32'(gnt), 0);
    chk("fl_sv_full", 32'(stage_valid), 32'h7);
    chk("fl_occ_full", 32'(occupancy), 3);
    next_cyc();
    exp_q.delete();
    drive(2'b00, 1'b0, 1'b0);
    chk("fl_sv", 32'(stage_valid), 0);
    chk("fl_occ", 32'(occupancy), 0);
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_done0", 32'(done0), 8);
    chk("fl_done1", 32'(done1), 3);
    next_cyc();

    // Asynchronous reset with two items in flight
    drive(2'b10, 1'b1, 1'b0);
    chk("ar_gnt1", 32'(gnt), 32'h2);
    exp_q.push_back(REQ1);
    next_cyc();
    drive(2'b01, 1'b1, 1'b0);
    chk("ar_gnt0", 32'(gnt), 32'h1);
    exp_q.push_back(REQ0);
    next_cyc();
    drive(2'b00, 1'b0, 1'b0);
    chk("ar_sv_011", 32'(stage_valid), 32'h3);
    next_cyc();
    drive(2'b00, 1'b0, 1'b0);
    chk("ar_out_valid_pre", 32'(out_valid), 1);
    chk("ar_sv_110", 32'(stage_valid), 32'h6);
    #2;
    reset = 1'b1;
    req = 2'b11;
    #1;
    chk("ar_out_valid", 32'(out_valid), 0);
    chk("ar_sv", 32'(stage_valid), 0);
    chk("ar_done0", 32'(done0), 0);
    chk("ar_done1", 32'(done1), 0);
    chk("ar_occ", 32'(occupancy), 0);
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_en", 32'(en), 32'h7);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    drive(2'b11, 1'b1, 1'b0);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    exp_q.push_back(REQ0);
    next_cyc();
    for (int c = 0; c < 2; c++) begin
      drive(2'b00, 1'b1, 1'b0);
      chk("post_rst_lat", 32'(out_valid), 0);
      next_cyc();
    end
    drive(2'b00, 1'b1, 1'b0);
    chk("post_rst_out_valid", 32'(out_valid), 1);
    next_cyc();
    drive(2'b00, 1'b0, 1'b0);
    chk("post_rst_done0", 32'(done0), 1);
    chk("post_rst_done1", 32'(done1), 0);
    chk("post_rst_occ", 32'(occupancy), 0);
    next_cyc();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
